rob_commit_unit: RTL and testbench

- Reorder-buffer bookkeeping and in-order retirement stage.
- Sits directly downstream of the CDB data controller, consuming its per-entry CDB_data_data, CDB_data_valid and CDB_data_addr vectors.
- Allocates entries to issuing instructions in program order, captures results as they appear on the CDB, and retires the head entry to the register file (loads/ALU) or to memory (stores), one per cycle.

---
 rtl/rob_commit_if.sv | 50 +++++
 rtl/rob_commit_unit.sv | 143 ++++++++++++++
 tb/tb_rob_commit_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Bundle between issue/CDB/commit sides and the reorder-buffer commit unit.
// The slave modport is the ROB view; master is the surrounding pipeline (or a bench).
interface rob_commit_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
);
  logic                         issue_valid;
  logic                         issue_is_store;
  logic [REG_INDEX-1:0]         issue_dest_reg;
  logic                         issue_ready;
  logic [RB_INDEX-1:0]          issue_rb_index;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
  logic                         mem_ready;
  logic                         flush;
  logic                         rf_we;
  logic [REG_INDEX-1:0]         rf_waddr;
  logic [WORD_SIZE-1:0]         rf_wdata;
  logic                         mem_we;
  logic [WORD_SIZE-1:0]         mem_addr;
  logic [WORD_SIZE-1:0]         mem_wdata;
  logic [RB_INDEX-1:0]          rb_head;
  logic [RB_INDEX-1:0]          rb_tail;
  logic [RB_INDEX:0]            rb_count;
  logic                         empty;
  logic                         full;

  modport master (
    output issue_valid, issue_is_store, issue_dest_reg,
    output CDB_data_data, CDB_data_valid, CDB_data_addr,
    output mem_ready, flush,
    input  issue_ready, issue_rb_index,
    input  rf_we, rf_waddr, rf_wdata,
    input  mem_we, mem_addr, mem_wdata,
    input  rb_head, rb_tail, rb_count, empty, full
  );

  modport slave (
    input  issue_valid, issue_is_store, issue_dest_reg,
    input  CDB_data_data, CDB_data_valid, CDB_data_addr,
    input  mem_ready, flush,
    output issue_ready, issue_rb_index,
    output rf_we, rf_waddr, rf_wdata,
    output mem_we, mem_addr, mem_wdata,
    output rb_head, rb_tail, rb_count, empty, full
  );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation, out-of-order result capture from the CDB
// (rising edge of each per-entry valid), and in-order single-entry retirement.
module rob_commit_unit #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
) (
  input  logic         clk,
  input  logic         reset,
  rob_commit_if.slave  bus
);

  localparam logic [RB_INDEX:0]   FULL_COUNT = (RB_INDEX+1)'(RB_SIZE);
  localparam logic [RB_INDEX:0]   COUNT_ONE  = (RB_INDEX+1)'(1);
  localparam logic [RB_INDEX-1:0] PTR_ONE    = RB_INDEX'(1);

  logic [RB_SIZE-1:0]   busy;
  logic [RB_SIZE-1:0]   done;
  logic [RB_SIZE-1:0]   is_store;
  logic [RB_SIZE-1:0]   prev_valid;
  logic [REG_INDEX-1:0] dest [RB_SIZE];
  logic [WORD_SIZE-1:0] data [RB_SIZE];
  logic [WORD_SIZE-1:0] addr [RB_SIZE];

  logic [RB_INDEX-1:0]  head;
  logic [RB_INDEX-1:0]  tail;
  logic [RB_INDEX:0]    count;

  logic                 rf_we;
  logic [REG_INDEX-1:0] rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;

  logic                 ready;
  logic                 allocate;
  logic                 commit;
  logic [RB_SIZE-1:0]   rise;

  // No allocation bypass when full: a same-cycle commit does not free a slot early.
  assign ready    = (count != FULL_COUNT) && !bus.flush;
  assign allocate = bus.issue_valid && ready;
  // Only a 0->1 transition counts, so a valid left high by a retired occupant is ignored.
  assign rise     = bus.CDB_data_valid & ~prev_valid;
  assign commit   = !bus.flush && busy[head] && done[head] &&
                    (!is_store[head] || bus.mem_ready);

  // Per-entry state: allocation, result capture, retirement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      done     <= '0;
      is_store <= '0;
      for (int i = 0; i < RB_SIZE; i++) begin
        dest[i] <= '0;
        data[i] <= '0;
        addr[i] <= '0;
      end
    end else if (bus.flush) begin
      busy <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < RB_SIZE; i++) begin
        if (allocate && tail == RB_INDEX'(i)) begin
          busy[i]     <= 1'b1;
          done[i]     <= 1'b0;
          is_store[i] <= bus.issue_is_store;
          dest[i]     <= bus.issue_dest_reg;
        end else if (busy[i] && !done[i] && rise[i]) begin
          done[i] <= 1'b1;
          data[i] <= bus.CDB_data_data[i*WORD_SIZE +: WORD_SIZE];
          addr[i] <= bus.CDB_data_addr[i*WORD_SIZE +: WORD_SIZE];
        end
        if (commit && head == RB_INDEX'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Pointers, occupancy and registered write pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      prev_valid <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      prev_valid <= bus.CDB_data_valid;
      rf_we      <= 1'b0;
      mem_we     <= 1'b0;
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (allocate) begin
          tail <= tail + PTR_ONE;
        end
        if (commit) begin
          head <= head + PTR_ONE;
          if (is_store[head]) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr[head];
            mem_wdata <= data[head];
          end else begin
            rf_we    <= 1'b1;
            rf_waddr <= dest[head];
            rf_wdata <= data[head];
          end
        end
        case ({allocate, commit})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.issue_ready    = ready;
  assign bus.issue_rb_index = tail;
  assign bus.rf_we          = rf_we;
  assign bus.rf_waddr       = rf_waddr;
  assign bus.rf_wdata       = rf_wdata;
  assign bus.mem_we         = mem_we;
  assign bus.mem_addr       = mem_addr;
  assign bus.mem_wdata      = mem_wdata;
  assign bus.rb_head        = head;
  assign bus.rb_tail        = tail;
  assign bus.rb_count       = count;
  assign bus.empty          = (count == '0);
  assign bus.full           = (count == FULL_COUNT);

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: in-order retirement, full/stall, store hold,
// pointer wrap, stale-valid rejection, flush and asynchronous reset.
module tb_rob_commit_unit;
  localparam int WS = 32;
  localparam int RS = 8;
  localparam int RI = 3;
  localparam int GI = 5;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rob_commit_if #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) bus ();

  rob_commit_unit #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int idx, input logic v);
    bus.CDB_data_valid[idx] = v;
  endtask

  task automatic set_cdb(input int idx, input logic [WS-1:0] d, input logic [WS-1:0] a);
    bus.CDB_data_data[idx*WS +: WS] = d;
    bus.CDB_data_addr[idx*WS +: WS] = a;
    bus.CDB_data_valid[idx]         = 1'b1;
  endtask

  task automatic issue(input logic [GI-1:0] d, input logic st);
    bus.issue_valid    = 1'b1;
    bus.issue_is_store = st;
    bus.issue_dest_reg = d;
    step();
    bus.issue_valid    = 1'b0;
    bus.issue_is_store = 1'b0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.issue_valid    = 1'b0;
    bus.issue_is_store = 1'b0;
    bus.issue_dest_reg = '0;
    bus.CDB_data_data  = '0;
    bus.CDB_data_addr  = '0;
    bus.CDB_data_valid = '0;
    bus.mem_ready      = 1'b1;
    bus.flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.rb_count, 0);
    check("rst_head", bus.rb_head, 0);
    check("rst_tail", bus.rb_tail, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_ready", bus.issue_ready, 1);

    // Three ALU ops, completed out of order, retired in order
    check("t1_idx0", bus.issue_rb_index, 0);
    issue(5'd1, 1'b0);
    issue(5'd2, 1'b0);
    issue(5'd3, 1'b0);
    check("t1_count3", bus.rb_count, 3);
    check("t1_tail3", bus.rb_tail, 3);
    set_cdb(2, 32'h22, 32'h0);
    step();
    check("t1_no_commit_a", bus.rf_we, 0);
    set_cdb(0, 32'h00, 32'h0);
    step();
    check("t1_no_commit_b", bus.rf_we, 0);
    set_cdb(1, 32'h11, 32'h0);
    step();
    check("t1_c0_we", bus.rf_we, 1);
    check("t1_c0_addr", bus.rf_waddr, 1);
    check("t1_c0_data", bus.rf_wdata, 32'h00);
    step();
    check("t1_c1_we", bus.rf_we, 1);
    check("t1_c1_addr", bus.rf_waddr, 2);
    check("t1_c1_data", bus.rf_wdata, 32'h11);
    step();
    check("t1_c2_we", bus.rf_we, 1);
    check("t1_c2_addr", bus.rf_waddr, 3);
    check("t1_c2_data", bus.rf_wdata, 32'h22);
    step();
    check("t1_we_drop", bus.rf_we, 0);
    check("t1_empty", bus.empty, 1);
    check("t1_head", bus.rb_head, 3);
    bus.CDB_data_valid = '0;
    step();

    // Fill to capacity, refuse a 9th, then free one slot
    do_reset();
    for (int k = 0; k < 8; k++) issue(5'(8 + k), 1'b0);
    check("t2_full", bus.full, 1);
    check("t2_ready0", bus.issue_ready, 0);
    check("t2_count8", bus.rb_count, 8);
    check("t2_tail_wrap", bus.rb_tail, 0);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    check("t2_tail_hold", bus.rb_tail, 0);
    check("t2_count_hold", bus.rb_count, 8);
    set_cdb(0, 32'h55, 32'h0);
    step();
    check("t2_no_commit", bus.rf_we, 0);
    step();
    check("t2_we", bus.rf_we, 1);
    check("t2_waddr", bus.rf_waddr, 8);
    check("t2_wdata", bus.rf_wdata, 32'h55);
    check("t2_count7", bus.rb_count, 7);
    check("t2_ready1", bus.issue_ready, 1);
    check("t2_head1", bus.rb_head, 1);
    step();
    check("t2_single_pulse", bus.rf_we, 0);
    check("t2_count7b", bus.rb_count, 7);

    // Store held at head by mem_ready=0
    do_reset();
    issue(5'd0, 1'b1);
    bus.mem_ready = 1'b0;
    set_cdb(0, 32'hABCD, 32'h100);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t3_stall_mem_we", bus.mem_we, 0);
      step();
    end
    check("t3_stall_count", bus.rb_count, 1);
    bus.mem_ready = 1'b1;
    step();
    check("t3_mem_we", bus.mem_we, 1);
    check("t3_mem_addr", bus.mem_addr, 32'h100);
    check("t3_mem_wdata", bus.mem_wdata, 32'hABCD);
    check("t3_no_rf_we", bus.rf_we, 0);
    step();
    check("t3_mem_we_drop", bus.mem_we, 0);
    check("t3_empty", bus.empty, 1);

    // Twelve allocate/complete/commit rounds to exercise pointer wrap
    do_reset();
    for (int k = 0; k < 12; k++) begin
      int idx;
      idx = k % 8;
      check("t4_idx", bus.issue_rb_index, idx);
      issue(5'(k + 1), 1'b0);
      check("t4_count1", bus.rb_count, 1);
      set_cdb(idx, 32'(k * 3 + 1), 32'h0);
      step();
      step();
      check("t4_wdata", bus.rf_wdata, 32'(k * 3 + 1));
      check("t4_head", bus.rb_head, (k + 1) % 8);
      check("t4_count0", bus.rb_count, 0);
      set_valid(idx, 1'b0);
    end
    check("t4_tail_end", bus.rb_tail, 4);

    // Stale valid from the previous occupant of idx0
    do_reset();
    issue(5'd4, 1'b0);
    set_cdb(0, 32'h77, 32'h0);
    step();
    step();
    check("t5_first_we", bus.rf_we, 1);
    check("t5_first_data", bus.rf_wdata, 32'h77);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t5_flush_tail", bus.rb_tail, 0);
    issue(5'd6, 1'b0);
    bus.CDB_data_data[0 +: WS] = 32'h99;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_stale_no_we", bus.rf_we, 0);
      check("t5_stale_count", bus.rb_count, 1);
    end
    set_valid(0, 1'b0);
    step();
    set_valid(0, 1'b1);
    step();
    check("t5_capture_no_we", bus.rf_we, 0);
    step();
    check("t5_we", bus.rf_we, 1);
    check("t5_waddr", bus.rf_waddr, 6);
    check("t5_wdata", bus.rf_wdata, 32'h99);

    // Flush with five busy entries, one of them ready to commit
    do_reset();
    for (int k = 0; k < 5; k++) issue(5'(10 + k), 1'b0);
    check("t6_count5", bus.rb_count, 5);
    set_cdb(0, 32'h33, 32'h0);
    step();
    check("t6_no_commit", bus.rf_we, 0);
    bus.flush = 1'b1;
    bus.issue_valid = 1'b1;
    #1;
    check("t6_ready_flush", bus.issue_ready, 0);
    step();
    check("t6_rf_we", bus.rf_we, 0);
    check("t6_count", bus.rb_count, 0);
    check("t6_head", bus.rb_head, 0);
    check("t6_tail", bus.rb_tail, 0);
    check("t6_empty", bus.empty, 1);
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    set_valid(0, 1'b0);
    step();

    // Asynchronous reset in the middle of an rf_we pulse
    issue(5'd9, 1'b0);
    set_cdb(0, 32'h5A, 32'h0);
    step();
    step();
    check("t7_pulse", bus.rf_we, 1);
    check("t7_pulse_data", bus.rf_wdata, 32'h5A);
    #2 reset = 1'b1;
    #1;
    check("t7_we_drop", bus.rf_we, 0);
    check("t7_wdata_clr", bus.rf_wdata, 0);
    check("t7_count", bus.rb_count, 0);
    check("t7_head", bus.rb_head, 0);
    check("t7_tail", bus.rb_tail, 0);
    check("t7_empty", bus.empty, 1);
    set_valid(0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
